// File: rtl/sc_movearbiter.sv
// Move scheduler: converts active-low buttons and a gravity timer into isolated,
// single-cycle point-register commands under a fixed priority.
module sc_movearbiter #(
    parameter int GRAVITY_TICKS = 25000000,
    parameter int CNT_WIDTH     = 25
) (
    input  logic       SC_MOVEARBITER_CLOCK_50,
    input  logic       SC_MOVEARBITER_RESET_InHigh,
    input  logic       SC_MOVEARBITER_startButton_InLow,
    input  logic       SC_MOVEARBITER_downButton_InLow,
    input  logic       SC_MOVEARBITER_leftButton_InLow,
    input  logic       SC_MOVEARBITER_rightButton_InLow,
    input  logic       SC_MOVEARBITER_bottomsidecomparator_InLow,
    output logic       SC_MOVEARBITER_clear_OutLow,
    output logic       SC_MOVEARBITER_load1_OutLow,
    output logic [1:0] SC_MOVEARBITER_shiftselection_Out,
    output logic       SC_MOVEARBITER_landed_OutHigh,
    output logic       SC_MOVEARBITER_running_OutHigh
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP} state_t;
    typedef enum logic [2:0] {
        C_START = 3'd0,
        C_DOWN  = 3'd1,
        C_LEFT  = 3'd2,
        C_RIGHT = 3'd3,
        C_GRAV  = 3'd4
    } cmd_t;

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(GRAVITY_TICKS - 1);

    logic clk;
    logic rst;
    assign clk = SC_MOVEARBITER_CLOCK_50;
    assign rst = SC_MOVEARBITER_RESET_InHigh;

    // Bit order matches the request priority: start, down, left, right.
    logic [3:0] btn_raw;
    assign btn_raw = {SC_MOVEARBITER_rightButton_InLow, SC_MOVEARBITER_leftButton_InLow,
                      SC_MOVEARBITER_downButton_InLow, SC_MOVEARBITER_startButton_InLow};

    logic [3:0] sync1_q, sync2_q, sync3_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '1;
            sync2_q <= '1;
            sync3_q <= '1;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
        end
    end

    state_t                 state_q;
    cmd_t                   cmd_q;
    logic [4:0]             pend_q, pend_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   running_q;

    // Falling edge of the synchronized level; only start is accepted before the game runs.
    logic [3:0] press;
    logic [3:0] press_ok;
    assign press    = sync3_q & ~sync2_q;
    assign press_ok = press & {{3{running_q}}, 1'b1};

    logic grav_wrap;
    logic start_done;
    assign grav_wrap  = running_q && (cnt_q == CNT_LAST);
    assign start_done = (state_q == S_ISSUE) && (cmd_q == C_START);

    logic [2:0] pick;
    logic       pick_vld;

    always_comb begin
        pick     = 3'd0;
        pick_vld = 1'b0;
        for (int i = 4; i >= 0; i--) begin
            if (pend_q[i]) begin
                pick     = 3'(i);
                pick_vld = 1'b1;
            end
        end
    end

    logic [4:0] set_vec;
    logic [4:0] clr_vec;
    assign set_vec = {grav_wrap, press_ok};

    always_comb begin
        clr_vec = '0;
        if (state_q == S_IDLE && pick_vld)
            clr_vec[pick] = 1'b1;
        if (start_done)
            clr_vec = '1;
    end

    // A request arriving in the cycle its flag is cleared survives.
    assign pend_d = (pend_q & ~clr_vec) | set_vec;

    always_comb begin
        cnt_d = cnt_q;
        if (start_done)
            cnt_d = '0;
        else if (running_q)
            cnt_d = grav_wrap ? '0 : cnt_q + CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cmd_q     <= C_START;
            pend_q    <= '0;
            cnt_q     <= '0;
            running_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        cmd_q   <= cmd_t'(pick);
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_GAP;
                    if (cmd_q == C_START)
                        running_q <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic issue;
    logic is_down;
    assign issue   = (state_q == S_ISSUE);
    assign is_down = (cmd_q == C_DOWN) || (cmd_q == C_GRAV);

    // The bottom-row comparator is looked at live in the issue cycle so a move never
    // acts on a stale row position.
    assign SC_MOVEARBITER_clear_OutLow   = ~(issue && cmd_q == C_START);
    assign SC_MOVEARBITER_load1_OutLow   = ~(issue && is_down && SC_MOVEARBITER_bottomsidecomparator_InLow);
    assign SC_MOVEARBITER_landed_OutHigh = issue && is_down && !SC_MOVEARBITER_bottomsidecomparator_InLow;
    assign SC_MOVEARBITER_running_OutHigh = running_q;

    always_comb begin
        SC_MOVEARBITER_shiftselection_Out = 2'b11;
        if (issue && cmd_q == C_LEFT)
            SC_MOVEARBITER_shiftselection_Out = 2'b01;
        else if (issue && cmd_q == C_RIGHT)
            SC_MOVEARBITER_shiftselection_Out = 2'b10;
    end

endmodule
